// File: rtl/padded_window_gen_pkg.sv
// Geometry and window tap-ordering constants shared by the padded window generator.
// The top level re-derives the geometry from its own parameters, so these are the defaults.
package padded_window_gen_pkg;
  localparam int QUAN_BITS = 8;
  localparam int CH        = 3;
  localparam int IMG_WIDTH = 32;
  localparam int IMG_HIGH  = 32;
  localparam int PIX_W     = QUAN_BITS * CH;
  localparam int PW        = IMG_WIDTH + 2;
  localparam int PH        = IMG_HIGH + 2;

  localparam int WIN_ROWS = 3;
  localparam int WIN_COLS = 3;
  localparam int WIN_TAPS = WIN_ROWS * WIN_COLS;

  // Tap k = 3*row + col; k=0 is top-left, k=8 is bottom-right.
  function automatic int tap_idx(input int row, input int col);
    return row * WIN_COLS + col;
  endfunction
endpackage

// File: rtl/padded_window_gen_window_line_buffer.sv
// Two padded rows of history, one entry per padded column.
// A write at addr returns the old contents of both rows on the same cycle.
module padded_window_gen_window_line_buffer #(
  parameter int PIX_W = 24,
  parameter int DEPTH = 34
) (
  input  logic                     s_clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [PIX_W-1:0]         wr_data,
  output logic [PIX_W-1:0]         rd_row0,
  output logic [PIX_W-1:0]         rd_row1
);

  logic [PIX_W-1:0] lb0_mem [DEPTH];
  logic [PIX_W-1:0] lb1_mem [DEPTH];

  assign rd_row0 = lb0_mem[addr];
  assign rd_row1 = lb1_mem[addr];

  // Row y-1 ages into row y-2 while the incoming pixel becomes the new row y-1.
  always_ff @(posedge s_clk) begin
    if (wr_en) begin
      lb0_mem[addr] <= lb1_mem[addr];
      lb1_mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/padded_window_gen.sv
// Turns the raster-order padded pixel stream into one 3x3 window per original pixel.
// A single output register holds the window; input stalls while it is unaccepted.
module padded_window_gen
  import padded_window_gen_pkg::*;
#(
  parameter int  QUAN_BITS = padded_window_gen_pkg::QUAN_BITS,
  parameter int  CH        = padded_window_gen_pkg::CH,
  parameter int  IMG_WIDTH = padded_window_gen_pkg::IMG_WIDTH,
  parameter int  IMG_HIGH  = padded_window_gen_pkg::IMG_HIGH,
  localparam int PIX_W     = QUAN_BITS * CH
) (
  input  logic                      s_clk,
  input  logic                      s_rst,
  output logic                      ready4data,
  input  logic [PIX_W-1:0]          pad_data_in,
  input  logic                      pad_data_valid,
  output logic [WIN_TAPS*PIX_W-1:0] win_data,
  output logic                      win_valid,
  input  logic                      win_ready,
  output logic                      win_last,
  output logic                      frame_done
);

  localparam int PW    = IMG_WIDTH + 2;
  localparam int PH    = IMG_HIGH + 2;
  localparam int XW    = $clog2(PW);
  localparam int YW    = $clog2(PH);
  localparam int COL_W = WIN_ROWS * PIX_W;
  localparam int WIN_W = WIN_TAPS * PIX_W;

  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [COL_W-1:0] col1_q, col1_d;
  logic [COL_W-1:0] col2_q, col2_d;
  logic [WIN_W-1:0] win_data_q, win_data_d;
  logic             win_valid_q, win_valid_d;
  logic             win_last_q, win_last_d;
  logic             frame_done_q, frame_done_d;

  logic             in_xfer;
  logic             win_load;
  logic [PIX_W-1:0] lb_top, lb_mid;
  logic [COL_W-1:0] new_col;
  logic [COL_W-1:0] win_cols [WIN_COLS];
  logic [WIN_W-1:0] win_next;

  assign ready4data = ~win_valid_q | win_ready;
  assign in_xfer    = pad_data_valid & ready4data;
  assign new_col    = {lb_top, lb_mid, pad_data_in};
  // Rows 0/1 and columns 0/1 only prime the buffers.
  assign win_load   = in_xfer && (x_q >= XW'(2)) && (y_q >= YW'(2));

  padded_window_gen_window_line_buffer #(
    .PIX_W (PIX_W),
    .DEPTH (PW)
  ) u_line_buffer (
    .s_clk   (s_clk),
    .wr_en   (in_xfer),
    .addr    (x_q),
    .wr_data (pad_data_in),
    .rd_row0 (lb_top),
    .rd_row1 (lb_mid)
  );

  // Columns are packed {top, middle, bottom}; the incoming column is the right edge.
  always_comb begin
    win_cols[0] = col1_q;
    win_cols[1] = col2_q;
    win_cols[2] = new_col;
    win_next    = '0;
    for (int r = 0; r < WIN_ROWS; r++) begin
      for (int c = 0; c < WIN_COLS; c++) begin
        win_next[tap_idx(r, c)*PIX_W +: PIX_W] = win_cols[c][(WIN_ROWS-1-r)*PIX_W +: PIX_W];
      end
    end
  end

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    col1_d       = col1_q;
    col2_d       = col2_q;
    win_data_d   = win_data_q;
    win_valid_d  = win_valid_q;
    win_last_d   = win_last_q;
    frame_done_d = win_valid_q & win_ready & win_last_q;

    if (in_xfer) begin
      col1_d = col2_q;
      col2_d = new_col;
      if (x_q == XW'(PW-1)) begin
        x_d = '0;
        y_d = (y_q == YW'(PH-1)) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end

    // A new load replaces an accepted window in the same cycle.
    if (win_load) begin
      win_valid_d = 1'b1;
      win_data_d  = win_next;
      win_last_d  = (x_q == XW'(PW-1)) && (y_q == YW'(PH-1));
    end else if (win_ready) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      x_q          <= '0;
      y_q          <= '0;
      win_data_q   <= '0;
      win_valid_q  <= 1'b0;
      win_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      win_data_q   <= win_data_d;
      win_valid_q  <= win_valid_d;
      win_last_q   <= win_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Column history is fully refilled before any window is emitted.
  always_ff @(posedge s_clk) begin
    col1_q <= col1_d;
    col2_q <= col2_d;
  end

  assign win_data   = win_data_q;
  assign win_valid  = win_valid_q;
  assign win_last   = win_last_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_padded_window_gen.sv
// Random-stimulus bench for padded_window_gen on a 4x4 image, checked against a
// frame-level window model built directly from the padded image.
module tb_padded_window_gen;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int PWT  = W + 2;
  localparam int PHT  = H + 2;
  localparam int PIXW = 24;
  localparam int WINW = 9 * PIXW;

  typedef struct {
    logic [WINW-1:0] data;
    logic            last;
  } exp_t;

  logic            s_clk;
  logic            s_rst;
  logic            ready4data;
  logic [PIXW-1:0] pad_data_in;
  logic            pad_data_valid;
  logic [WINW-1:0] win_data;
  logic            win_valid;
  logic            win_ready;
  logic            win_last;
  logic            frame_done;

  padded_window_gen #(
    .QUAN_BITS (8),
    .CH        (3),
    .IMG_WIDTH (W),
    .IMG_HIGH  (H)
  ) dut (
    .s_clk          (s_clk),
    .s_rst          (s_rst),
    .ready4data     (ready4data),
    .pad_data_in    (pad_data_in),
    .pad_data_valid (pad_data_valid),
    .win_data       (win_data),
    .win_valid      (win_valid),
    .win_ready      (win_ready),
    .win_last       (win_last),
    .frame_done     (frame_done)
  );

  initial s_clk = 1'b0;
  always #5 s_clk = ~s_clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int win_cnt = 0, last_cnt = 0, done_cnt = 0, stall_cnt = 0;
  int first_valid_cyc = -1, lat_expect = -2, frame_xfer = 0;
  int cap_a = -1, cap_b = -1;
  bit rec_lat = 0, rnd_ready = 0, bp_arm = 0, stall_prev = 0, done_exp = 0;
  int hold = 0;
  logic [WINW-1:0] cap_win_a, cap_win_b, prev_data;
  logic [PIXW-1:0] pix_q [$];
  exp_t            exp_q [$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PIXW-1:0] rep(input int v);
    logic [7:0] b;
    b = 8'(v);
    return {b, b, b};
  endfunction

  // Reference: pad the image, stream it raster-order, and list the window centred on each pixel.
  task automatic add_frame(input int off);
    logic [PIXW-1:0] img [PHT][PWT];
    exp_t e;
    for (int py = 0; py < PHT; py++)
      for (int px = 0; px < PWT; px++) begin
        if (py == 0 || px == 0 || py == PHT-1 || px == PWT-1) img[py][px] = '0;
        else img[py][px] = rep((py-1)*W + (px-1) + 1 + off);
        pix_q.push_back(img[py][px]);
      end
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        e.data = '0;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            e.data[(3*dr+dc)*PIXW +: PIXW] = img[r+dr][c+dc];
        e.last = (r == H-1) && (c == W-1);
        exp_q.push_back(e);
      end
  endtask

  task automatic set_ready();
    if (bp_arm && win_valid) begin
      hold   = 10;
      bp_arm = 0;
    end
    if (hold > 0) begin
      win_ready = 1'b0;
      hold--;
    end else begin
      win_ready = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
    end
  endtask

  task automatic drive(input int gap_pct, input int max_xfer);
    int sent = 0;
    int guard = 0;
    while (pix_q.size() > 0 && sent < max_xfer && guard < 5000) begin
      @(posedge s_clk); #1;
      set_ready();
      pad_data_valid = ($urandom_range(99) >= gap_pct);
      pad_data_in    = pix_q[0];
      @(negedge s_clk);
      if (pad_data_valid && ready4data) begin
        void'(pix_q.pop_front());
        sent++;
        frame_xfer++;
        if (rec_lat && frame_xfer == 15) lat_expect = cyc + 1;
      end
      guard++;
    end
    if (guard >= 5000) chk("drive_timeout", guard, 0);
    @(posedge s_clk); #1;
    pad_data_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(posedge s_clk); #1;
      set_ready();
      @(negedge s_clk);
      if (exp_q.size() == 0 && !win_valid) done = 1;
    end
    if (!done) chk("drain_timeout", exp_q.size(), 0);
    repeat (3) @(negedge s_clk);
    win_ready = 1'b1;
  endtask

  int b_w, b_l, b_d, b_s;
  task automatic mark();
    b_w = win_cnt; b_l = last_cnt; b_d = done_cnt; b_s = stall_cnt;
  endtask

  initial begin
    exp_t e;
    s_rst          = 1'b1;
    pad_data_valid = 1'b0;
    pad_data_in    = '0;
    win_ready      = 1'b1;

    fork
      forever @(posedge s_clk) cyc++;
      forever begin
        @(negedge s_clk);
        if (s_rst) begin
          exp_q.delete();
          stall_prev = 0;
          done_exp   = 0;
        end else begin
          chk("ready4data", ready4data, !win_valid || win_ready);
          chk("frame_done", frame_done, done_exp);
          done_exp = 0;
          if (stall_prev) begin
            chk("hold_valid", win_valid, 1'b1);
            chk("hold_data", win_data, prev_data);
          end
          if (win_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
          stall_prev = win_valid && !win_ready;
          prev_data  = win_data;
          if (stall_prev) stall_cnt++;
          if (win_valid && win_ready) begin
            if (exp_q.size() == 0) chk("win_extra", exp_q.size(), 1);
            else begin
              e = exp_q.pop_front();
              chk("win_data", win_data, e.data);
              chk("win_last", win_last, e.last);
              if (win_cnt == cap_a) cap_win_a = win_data;
              if (win_cnt == cap_b) cap_win_b = win_data;
              win_cnt++;
              if (win_last) last_cnt++;
              done_exp = e.last;
            end
          end
          if (frame_done) done_cnt++;
        end
      end
    join_none

    repeat (3) @(negedge s_clk);
    chk("rst_ready4data", ready4data, 1'b1);
    chk("rst_win_valid", win_valid, 1'b0);
    chk("rst_win_last", win_last, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_win_data", win_data, '0);
    @(posedge s_clk); #1;
    s_rst = 1'b0;

    // Basic geometry and first-window latency
    mark();
    cap_a = win_cnt; cap_b = win_cnt + 15;
    first_valid_cyc = -1; frame_xfer = 0; rec_lat = 1;
    add_frame(0);
    drive(0, 1000);
    drain();
    rec_lat = 0;
    chk("p1_latency", first_valid_cyc, lat_expect);
    chk("p1_wins", win_cnt - b_w, 16);
    chk("p1_last", last_cnt - b_l, 1);
    chk("p1_done", done_cnt - b_d, 1);
    chk("p1_first_t4", cap_win_a[4*PIXW +: PIXW], 24'h010101);
    chk("p1_first_t5", cap_win_a[5*PIXW +: PIXW], 24'h020202);
    chk("p1_first_t7", cap_win_a[7*PIXW +: PIXW], 24'h050505);
    chk("p1_first_t8", cap_win_a[8*PIXW +: PIXW], 24'h060606);
    chk("p1_last_t0", cap_win_b[0*PIXW +: PIXW], 24'h0b0b0b);
    chk("p1_last_t4", cap_win_b[4*PIXW +: PIXW], 24'h101010);

    // Backpressure on the first window
    mark();
    bp_arm = 1;
    add_frame(0);
    drive(0, 1000);
    drain();
    chk("p2_stall", stall_cnt - b_s, 10);
    chk("p2_wins", win_cnt - b_w, 16);
    chk("p2_done", done_cnt - b_d, 1);

    // Gapped input with random window acceptance
    mark();
    rnd_ready = 1;
    add_frame(0);
    drive(40, 1000);
    drain();
    rnd_ready = 0;
    chk("p3_wins", win_cnt - b_w, 16);
    chk("p3_last", last_cnt - b_l, 1);
    chk("p3_done", done_cnt - b_d, 1);

    // Back-to-back frames
    mark();
    cap_a = win_cnt + 16;
    add_frame(0);
    add_frame(100);
    drive(0, 1000);
    drain();
    chk("p4_wins", win_cnt - b_w, 32);
    chk("p4_last", last_cnt - b_l, 2);
    chk("p4_done", done_cnt - b_d, 2);
    chk("p4_f2_t0_3", cap_win_a[4*PIXW-1:0], '0);
    chk("p4_f2_t4", cap_win_a[4*PIXW +: PIXW], 24'h656565);

    // Mid-frame reset with a window held
    add_frame(0);
    drive(0, 20);
    @(posedge s_clk); #1;
    win_ready      = 1'b0;
    pad_data_valid = 1'b1;
    pad_data_in    = pix_q[0];
    @(posedge s_clk); #1;
    pad_data_valid = 1'b0;
    chk("p5_pre_rst_valid", win_valid, 1'b1);
    s_rst = 1'b1;
    #1;
    chk("p5_rst_valid", win_valid, 1'b0);
    chk("p5_rst_ready", ready4data, 1'b1);
    pix_q.delete();
    win_ready = 1'b1;
    repeat (2) @(negedge s_clk);
    @(posedge s_clk); #1;
    s_rst = 1'b0;
    mark();
    add_frame(0);
    drive(0, 1000);
    drain();
    chk("p5_wins", win_cnt - b_w, 16);
    chk("p5_last", last_cnt - b_l, 1);
    chk("p5_done", done_cnt - b_d, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
